adc_deser: RTL and testbench
============================

Name: adc_deser

Overview:
- Parametrised serial-to-parallel collector for the ADC front end. Successor to the fixed 4-bit single-channel collector.
- Shifts NUM_CH serial ADC lines in lockstep, MSB first, into WORD_W-bit words.
- Word boundaries are set by an explicit frame strobe rather than a free-running counter.
- Completed words are buffered in a small FIFO and delivered over a valid/ready handshake to the sample-processing logic.

Parameters:
- WORD_W, 4, bits per sample word (2..32)
- NUM_CH, 1, parallel serial ADC lines, sampled in lockstep (1..8)
- FIFO_DEPTH, 4, word-vector entries buffered; power of two, >=2

Ports:
- clk, in, 1, system clock; all logic on rising edge
- rst_n, in, 1, asynchronous active-low reset; deassertion synchronised externally
- sdi, in, NUM_CH, serial data, one bit per channel
- bit_en, in, 1, sdi qualifier; bits captured only when high
- frame, in, 1, start-of-word marker; meaningful only with bit_en
- out_data, out, NUM_CH*WORD_W, channel c occupies bits [c*WORD_W +: WORD_W]
- out_valid, out, 1, FIFO head valid
- out_ready, in, 1, consumer accepts head when out_valid & out_ready
- overflow, out, 1, sticky: a completed word was dropped because the FIFO was full
- clr_ovf, in, 1, synchronous clear of overflow (and frame_err when compiled in)
- level, out, clog2(FIFO_DEPTH)+1, FIFO occupancy

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; bit counter=0; shift regs=0; FIFO empty.
  - out_valid=0, out_data=0, overflow=0, level=0.
- FSM IDLE:
  - bit_en & frame: capture sdi as MSB of every channel, counter=1, go SHIFT.
  - bit_en without frame: ignored.
- FSM SHIFT:
  - Each bit_en cycle shifts sdi in (left shift, new bit at LSB) and increments the counter.
  - Cycles with bit_en low hold all state.
- Word completion:
  - Occurs on the bit_en cycle where the counter reaches WORD_W.
  - The assembled vector is pushed into the FIFO on that edge; FSM returns to IDLE.
  - If frame is also high that cycle, the push still happens and the FSM stays in SHIFT only if WORD_W==1; otherwise the frame is treated per the mid-word rule below.
- Back-to-back words:
  - A frame on the first bit_en cycle after completion starts the next word.
  - No dead cycle is required.
- Mid-word frame (SHIFT, counter<WORD_W, bit_en & frame):
  - Partial word discarded.
  - Current bit becomes the new MSB; counter=1.
- Latency: last bit edge N -> out_valid=1 and out_data valid after edge N (visible in cycle N+1) when the FIFO was empty.
- FIFO:
  - out_data is driven from the registered head entry.
  - Pop on out_valid & out_ready.
  - out_data is held stable while out_valid & !out_ready.
  - Push when full and no pop same cycle: word dropped, overflow<=1, level unchanged.
  - Push and pop same cycle when full: both occur; no overflow.
  - Push and pop same cycle when empty: word stored, then presented next cycle; no bypass.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - level = write count minus read count, range 0..FIFO_DEPTH.
- Sticky flags:
  - overflow is cleared only by clr_ovf or reset.
  - If clr_ovf and a new overflow coincide, the flag ends set (set wins).
- Reset mid-word: partial word and all FIFO contents are lost; no output glitch beyond reset values.

Optional Feature:
- Macro: ADC_DESER_FRAME_ERR_EN.
- Defined:
  - Adds output frame_err (1 bit, reset 0).
  - Sticky-set on any mid-word frame; cleared by clr_ovf; set wins over clear.
  - Adds output err_cnt (8 bits, reset 0), counting mid-word frames and saturating at 255; cleared by clr_ovf.
- Undefined:
  - Neither port exists.
  - A mid-word frame silently restarts the word; all other behaviour is identical.

Decomposition:
- Package adc_pkg:
  - Default WORD_W/NUM_CH/FIFO_DEPTH constants.
  - FSM state enum (IDLE, SHIFT).
  - Helper constant function for pointer width (clog2).
- Sub-module adc_word_fifo:
  - Synchronous FIFO with registered output, full/empty/level, and a drop-on-full push.
  - Parametrised by data width NUM_CH*WORD_W and FIFO_DEPTH.
- The FSM and shift registers remain in adc_deser.

Test Plan:
- Basic word, WORD_W=4, NUM_CH=1, out_ready=1:
  - Stimulus: frame+bit_en with sdi 1,0,1,1 over 4 consecutive cycles.
  - Response: out_data=4'hB, out_valid high exactly 1 cycle starting cycle after last bit.
- Multichannel, NUM_CH=2:
  - Stimulus: ch0 bits 1,1,0,0 and ch1 bits 0,1,0,1.
  - Response: out_data=8'h5C.
  - Also: bit_en gaps between bits give the same result.
- Backpressure/overflow, FIFO_DEPTH=4, out_ready=0:
  - Stimulus: push 5 words 1..5.
  - Response: level=4, overflow=1, head=1.
  - Then ready=1: words 1,2,3,4 emerge in order and level reaches 0.
  - Then clr_ovf pulse: overflow=0.
- Full with simultaneous pop and push:
  - Response: no overflow; level stays 4; the new word is delivered last.
- Mid-word frame:
  - Stimulus: bits 1,0 then frame with bits 0,1,1,0.
  - Response: single word 4'h6; frame_err=1 and err_cnt=1 when ADC_DESER_FRAME_ERR_EN is defined.
- Async reset asserted mid-word with a non-empty FIFO:
  - Response: out_valid=0, level=0, overflow=0 immediately, with no clock required.
  - After release: the next framed word is assembled correctly.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared defaults, FSM state type and width helper for the adc_deser block.
package adc_pkg;

    localparam int DEF_WORD_W     = 4;
    localparam int DEF_NUM_CH     = 1;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/adc_deser_if.sv
// Valid/ready word stream from the deserialiser to the sample-processing logic.
interface adc_deser_if #(
    parameter int NUM_CH = 1,
    parameter int WORD_W = 4
) ();
    logic [NUM_CH*WORD_W-1:0] out_data;
    logic                     out_valid;
    logic                     out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/adc_word_fifo.sv
// Synchronous word FIFO: registered storage, occupancy level and drop-on-full push.
module adc_word_fifo
    import adc_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [DATA_W-1:0]      push_data,
    input  logic                   pop,
    output logic [DATA_W-1:0]      dout,
    output logic                   valid,
    output logic [clog2(DEPTH):0]  level,
    output logic                   drop
);
    localparam int PW = clog2(DEPTH);
    localparam logic [PW:0] LVL_FULL = DEPTH[PW:0];

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW:0]       wr_ptr, rd_ptr;
    logic              full, pop_ok, push_ok;

    // Pointers carry one extra wrap bit so full and empty stay distinguishable.
    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == LVL_FULL);
    assign valid   = (level != '0);
    assign pop_ok  = pop & valid;
    assign push_ok = push & (~full | pop_ok);
    assign drop    = push & full & ~pop_ok;
    assign dout    = valid ? mem[rd_ptr[PW-1:0]] : '0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage has no reset; stale entries are unreachable because dout is gated by valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[PW-1:0]] <= push_data;
    end

endmodule

// File: rtl/adc_deser.sv
// NUM_CH-lane serial-to-parallel collector with framed words and a buffered output stream.
// Optional frame_err/err_cnt outputs are compiled in with `define ADC_DESER_FRAME_ERR_EN.
module adc_deser
    import adc_pkg::*;
#(
    parameter int WORD_W     = DEF_WORD_W,
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CH-1:0]           sdi,
    input  logic                        bit_en,
    input  logic                        frame,
    adc_deser_if.master                 out_if,
    output logic                        overflow,
    input  logic                        clr_ovf,
    output logic [clog2(FIFO_DEPTH):0]  level
`ifdef ADC_DESER_FRAME_ERR_EN
    ,
    output logic                        frame_err,
    output logic [7:0]                  err_cnt
`endif
);
    localparam int CW = clog2(WORD_W + 1);
    localparam logic [CW-1:0] LAST = CW'(WORD_W - 1);

    state_t                state, state_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [WORD_W-1:0]     sh [NUM_CH];
    logic [WORD_W-1:0]     sh_n [NUM_CH];
    logic [WORD_W-1:0]     shifted [NUM_CH];
    logic [WORD_W-1:0]     first [NUM_CH];
    logic [NUM_CH*WORD_W-1:0] push_word;
    logic                  push, mid_frame, drop;

    always_comb begin
        push_word = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            shifted[c] = {sh[c][WORD_W-2:0], sdi[c]};
            first[c]   = WORD_W'(sdi[c]);
            push_word[c*WORD_W +: WORD_W] = shifted[c];
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        sh_n      = sh;
        push      = 1'b0;
        mid_frame = 1'b0;
        case (state)
            IDLE: begin
                if (bit_en && frame) begin
                    sh_n    = first;
                    cnt_n   = CW'(1);
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_en) begin
                    if (cnt == LAST) begin
                        push    = 1'b1;
                        sh_n    = shifted;
                        cnt_n   = '0;
                        state_n = IDLE;
                    end else if (!frame) begin
                        sh_n  = shifted;
                        cnt_n = cnt + CW'(1);
                    end
                    // A frame restarts the word with this bit as MSB; a completing word is still pushed.
                    if (frame) begin
                        sh_n      = first;
                        cnt_n     = CW'(1);
                        state_n   = SHIFT;
                        mid_frame = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            for (int c = 0; c < NUM_CH; c++) sh[c] <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            sh    <= sh_n;
        end
    end

    adc_word_fifo #(
        .DATA_W (NUM_CH*WORD_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_word),
        .pop       (out_if.out_ready),
        .dout      (out_if.out_data),
        .valid     (out_if.out_valid),
        .level     (level),
        .drop      (drop)
    );

    // Sticky flags: a new event in the same cycle as clr_ovf leaves the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        overflow <= 1'b0;
        else if (drop)     overflow <= 1'b1;
        else if (clr_ovf)  overflow <= 1'b0;
    end

`ifdef ADC_DESER_FRAME_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
            err_cnt   <= '0;
        end else begin
            if (mid_frame)    frame_err <= 1'b1;
            else if (clr_ovf) frame_err <= 1'b0;
            if (clr_ovf)
                err_cnt <= mid_frame ? 8'd1 : 8'd0;
            else if (mid_frame && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
        end
    end
`else
    logic unused_mid_frame;
    assign unused_mid_frame = mid_frame;
`endif

endmodule

// File: tb/tb_adc_deser.sv
// Self-checking bench for adc_deser (WORD_W=4, NUM_CH=2, FIFO_DEPTH=4) against a queue-based model.
module tb_adc_deser;
    localparam int WW    = 4;
    localparam int NCH   = 2;
    localparam int DEPTH = 4;
    localparam int DW    = WW * NCH;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [NCH-1:0] sdi = '0;
    logic           bit_en = 1'b0;
    logic           frame = 1'b0;
    logic           clr_ovf = 1'b0;
    logic           overflow;
    logic [LW-1:0]  level;
`ifdef ADC_DESER_FRAME_ERR_EN
    logic           frame_err;
    logic [7:0]     err_cnt;
`endif

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    logic [DW-1:0]  exp_q[$];
    logic [NCH-1:0] bits_q[$];
    bit             active = 0;
    bit             m_ovf = 0;
    bit             m_ferr = 0;
    int             m_ecnt = 0;

    adc_deser_if #(.NUM_CH(NCH), .WORD_W(WW)) bus ();

    adc_deser #(.WORD_W(WW), .NUM_CH(NCH), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sdi      (sdi),
        .bit_en   (bit_en),
        .frame    (frame),
        .out_if   (bus),
        .overflow (overflow),
        .clr_ovf  (clr_ovf),
        .level    (level)
`ifdef ADC_DESER_FRAME_ERR_EN
        ,
        .frame_err (frame_err),
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        exp_q.delete();
        bits_q.delete();
        active = 0;
        m_ovf  = 0;
        m_ferr = 0;
        m_ecnt = 0;
    endtask

    // Advance one clock: update the model from the current inputs, then move to 1 time unit past the edge.
    task automatic tick();
        logic [DW-1:0] w;
        bit do_push, do_pop, drop, mid;
        w = '0;
        do_push = 0;
        mid = 0;
        do_pop = (exp_q.size() != 0) && bus.out_ready;
        if (bit_en) begin
            if (frame) begin
                mid = active;
                bits_q.delete();
                bits_q.push_back(sdi);
                active = 1;
            end else if (active) begin
                bits_q.push_back(sdi);
            end
            if (active && bits_q.size() == WW) begin
                for (int i = 0; i < WW; i++)
                    for (int c = 0; c < NCH; c++)
                        w[c*WW + (WW-1-i)] = bits_q[i][c];
                do_push = 1;
                active = 0;
                bits_q.delete();
            end
        end
        drop = do_push && (exp_q.size() == DEPTH) && !do_pop;
        if (do_pop) void'(exp_q.pop_front());
        if (do_push && !drop) exp_q.push_back(w);
        if (drop) m_ovf = 1;
        else if (clr_ovf) m_ovf = 0;
        if (mid) begin
            m_ferr = 1;
            if (clr_ovf) m_ecnt = 0;
            if (m_ecnt < 255) m_ecnt++;
        end else if (clr_ovf) begin
            m_ferr = 0;
            m_ecnt = 0;
        end
        @(posedge clk);
        #1;
    endtask

    // Send one framed word (MSB first per channel); rdy_last >= 0 forces out_ready on the final bit.
    task automatic send_word(input logic [DW-1:0] v, input int max_gap, input int rdy_last);
        for (int i = 0; i < WW; i++) begin
            int g;
            g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            for (int k = 0; k < g; k++) begin
                bit_en = 1'b0;
                frame  = 1'($urandom_range(1, 0));
                sdi    = NCH'($urandom);
                tick();
            end
            if (i == WW-1 && rdy_last >= 0) bus.out_ready = rdy_last[0];
            bit_en = 1'b1;
            frame  = (i == 0);
            for (int c = 0; c < NCH; c++) sdi[c] = v[c*WW + WW-1-i];
            tick();
        end
        bit_en = 1'b0;
        frame  = 1'b0;
    endtask

    task automatic test_reset();
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL reset_data: got %h expected 00", bus.out_data); end
        checks++; if (level !== '0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
        rst_n = 1'b1;
        model_reset();
        tick();
    endtask

    task automatic test_basic();
        bus.out_ready = 1'b1;
        // ch0 = 1,0,1,1 ; ch1 = 0,1,1,0
        send_word(8'h6B, 0, -1);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", bus.out_valid); end
        checks++; if (bus.out_data[WW-1:0] !== 4'hB) begin errors++; $display("FAIL basic_ch0: got %h expected b", bus.out_data[WW-1:0]); end
        checks++; if (bus.out_data !== 8'h6B) begin errors++; $display("FAIL basic_data: got %h expected 6b", bus.out_data); end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_one_cycle: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_multichannel();
        bus.out_ready = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            // ch0 = 1,1,0,0 ; ch1 = 0,1,0,1 ; second pass adds bit_en gaps
            send_word(8'h5C, pass * 3, -1);
            checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h5C)
                begin errors++; $display("FAIL multi_pass%0d: got v=%b d=%h expected v=1 d=5c", pass, bus.out_valid, bus.out_data); end
            tick();
        end
    endtask

    task automatic test_overflow();
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) send_word({4'(k), 4'(k)}, 0, -1);
        checks++; if (level !== LW'(4)) begin errors++; $display("FAIL ovf_level: got %0d expected 4", level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
        checks++; if (bus.out_data !== 8'h11) begin errors++; $display("FAIL ovf_head: got %h expected 11", bus.out_data); end
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== {4'(k), 4'(k)})
                begin errors++; $display("FAIL ovf_drain%0d: got v=%b d=%h expected v=1 d=%h", k, bus.out_valid, bus.out_data, {4'(k), 4'(k)}); end
            tick();
        end
        checks++; if (level !== '0) begin errors++; $display("FAIL ovf_empty: got %0d expected 0", level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
    endtask

    task automatic test_full_push_pop();
        logic [DW-1:0] order [5];
        order = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hE5};
        bus.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) send_word(order[k], 0, -1);
        send_word(order[4], 0, 1);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_ovf: got %b expected 0", overflow); end
        checks++; if (level !== LW'(4)) begin errors++; $display("FAIL fpp_level: got %0d expected 4", level); end
        for (int k = 1; k < 5; k++) begin
            checks++; if (bus.out_data !== order[k])
                begin errors++; $display("FAIL fpp_order%0d: got %h expected %h", k, bus.out_data, order[k]); end
            tick();
        end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL fpp_empty: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_midword();
        logic [NCH-1:0] pat [6];
        logic           frm [6];
        pat = '{2'b11, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00};
        frm = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bit_en = 1'b1;
            frame  = frm[i];
            sdi    = pat[i];
            tick();
            if (i == 1) begin
                checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_partial: got %b expected 0", bus.out_valid); end
            end
        end
        bit_en = 1'b0;
        frame  = 1'b0;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h66)
            begin errors++; $display("FAIL mid_word: got v=%b d=%h expected v=1 d=66", bus.out_valid, bus.out_data); end
`ifdef ADC_DESER_FRAME_ERR_EN
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL mid_ferr: got %b expected 1", frame_err); end
        checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL mid_ecnt: got %0d expected 1", err_cnt); end
`endif
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_single: got %b expected 0", bus.out_valid); end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
`ifdef ADC_DESER_FRAME_ERR_EN
        checks++; if (frame_err !== 1'b0 || err_cnt !== 8'd0)
            begin errors++; $display("FAIL mid_clear: got ferr=%b cnt=%0d expected 0/0", frame_err, err_cnt); end
`endif
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            bit_en = ($urandom_range(9, 0) < 7);
            if (!active) frame = ($urandom_range(9, 0) < 4);
            else if (bits_q.size() == WW-1) frame = 1'b0;
            else frame = ($urandom_range(19, 0) == 0);
            sdi = NCH'($urandom);
            bus.out_ready = 1'($urandom_range(1, 0));
            clr_ovf = ($urandom_range(29, 0) == 0);
            tick();
            checks++; if (bus.out_valid !== (exp_q.size() != 0))
                begin errors++; $display("FAIL rnd_valid@%0d: got %b expected %b", n, bus.out_valid, exp_q.size() != 0); end
            checks++; if (bus.out_data !== ((exp_q.size() != 0) ? exp_q[0] : '0))
                begin errors++; $display("FAIL rnd_data@%0d: got %h expected %h", n, bus.out_data, (exp_q.size() != 0) ? exp_q[0] : '0); end
            checks++; if (level !== LW'(exp_q.size()))
                begin errors++; $display("FAIL rnd_level@%0d: got %0d expected %0d", n, level, exp_q.size()); end
            checks++; if (overflow !== m_ovf)
                begin errors++; $display("FAIL rnd_ovf@%0d: got %b expected %b", n, overflow, m_ovf); end
`ifdef ADC_DESER_FRAME_ERR_EN
            checks++; if (frame_err !== m_ferr || err_cnt !== 8'(m_ecnt))
                begin errors++; $display("FAIL rnd_ferr@%0d: got %b/%0d expected %b/%0d", n, frame_err, err_cnt, m_ferr, m_ecnt); end
`endif
        end
        bit_en = 1'b0;
        frame = 1'b0;
        clr_ovf = 1'b0;
        bus.out_ready = 1'b1;
        repeat (DEPTH + 2) tick();
        checks++; if (level !== '0) begin errors++; $display("FAIL rnd_drain: got %0d expected 0", level); end
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) send_word(DW'($urandom), 0, -1);
        bit_en = 1'b1; frame = 1'b1; sdi = 2'b11; tick();
        frame = 1'b0; sdi = 2'b01; tick();
        checks++; if (overflow !== 1'b1 || level !== LW'(4))
            begin errors++; $display("FAIL ar_pre: got ovf=%b lvl=%0d expected 1/4", overflow, level); end
        bit_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b expected 0", bus.out_valid); end
        checks++; if (level !== '0) begin errors++; $display("FAIL ar_level: got %0d expected 0", level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ar_ovf: got %b expected 0", overflow); end
        checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL ar_data: got %h expected 00", bus.out_data); end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        send_word(8'h3A, 0, 1);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h3A)
            begin errors++; $display("FAIL ar_after: got v=%b d=%h expected v=1 d=3a", bus.out_valid, bus.out_data); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_multichannel();
        test_overflow();
        test_full_push_pop();
        test_midword();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
